// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the DMEM port arbiter.
package dmem_arb_pkg;

    localparam int XLEN         = 32;
    localparam int DMEM_WIDTH   = 12;
    localparam int ARB_NREQ     = 3;
    localparam int ARB_NREQ_MAX = 8;
    localparam int ARB_MEM_LAT  = 1;
    localparam int ARB_LOCK_MAX = 16;
    localparam int PIPE_DEPTH   = 1 + ARB_MEM_LAT;

    // Requester ids are sized for the largest supported requester count so the
    // in-flight record keeps one layout whatever NREQ a given instance uses.
    localparam int ID_W = $clog2(ARB_NREQ_MAX);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        logic            we;
    } inflight_t;

endpackage

// File: rtl/dmem_rr_picker.sv
// Rotate-priority one-hot picker: the first set request at or after ptr wins.
module dmem_rr_picker #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);

    localparam int PTR_W = $clog2(NREQ);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk the requesters starting at ptr, wrapping modulo NREQ, and grant the first hit.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ)) begin
                sum = sum - (PTR_W+1)'(NREQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one DMEM port between NREQ requesters, with a
// bounded grant lock for read-modify-write sequences and in-order responses.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ     = ARB_NREQ,
    parameter int ADDR_W   = DMEM_WIDTH,
    parameter int DATA_W   = XLEN,
    parameter int MEM_LAT  = ARB_MEM_LAT,
    parameter int LOCK_MAX = ARB_LOCK_MAX
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*4-1:0]        req_be,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic                     rsp_we,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     mem_rden,
    output logic                     mem_wren,
    output logic [3:0]               mem_byteena,
    input  logic [DATA_W-1:0]        mem_q
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int DEPTH = 1 + MEM_LAT;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    localparam logic UNLOCKED = 1'b0;
    localparam logic LOCKED   = 1'b1;

    logic             state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] lock_id;
    logic [CNT_W-1:0] lock_cnt;

    logic [NREQ-1:0]   req_elig;
    logic [NREQ-1:0]   gnt;
    logic              accept;
    logic [PTR_W-1:0]  acc_id;
    logic [PTR_W-1:0]  acc_next;
    logic [PTR_W-1:0]  lock_next;
    logic              acc_we;
    logic              acc_lock;
    logic [ADDR_W-1:0] acc_addr;
    logic [3:0]        acc_be;
    logic [DATA_W-1:0] acc_wdata;
    logic              lock_expire;
    logic              owner_unlock;

    inflight_t pipe_p [DEPTH];
    inflight_t tail;

    // While locked only the owner may compete; nothing is granted while reset is held.
    assign req_elig = !rst_n           ? '0 :
                      (state == LOCKED) ? (req_valid & (NREQ'(1) << lock_id)) :
                                          req_valid;

    dmem_rr_picker #(.NREQ(NREQ)) u_picker (
        .req (req_elig),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    // Select the winning requester's command fields.
    always_comb begin
        acc_id    = '0;
        acc_we    = 1'b0;
        acc_lock  = 1'b0;
        acc_addr  = '0;
        acc_be    = '0;
        acc_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                acc_id    = PTR_W'(i);
                acc_we    = req_we[i];
                acc_lock  = req_lock[i];
                acc_addr  = req_addr[i*ADDR_W +: ADDR_W];
                acc_be    = req_be[i*4 +: 4];
                acc_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign acc_next     = (acc_id  == PTR_W'(NREQ-1)) ? '0 : acc_id  + PTR_W'(1);
    assign lock_next    = (lock_id == PTR_W'(NREQ-1)) ? '0 : lock_id + PTR_W'(1);
    assign lock_expire  = (state == LOCKED) && (lock_cnt == CNT_W'(LOCK_MAX-1));
    assign owner_unlock = (state == LOCKED) && accept && !acc_lock;

    // Pointer and lock FSM; the lock counter runs from lock set whether or not the owner issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            ptr      <= '0;
            lock_id  <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (accept) begin
                        ptr <= acc_next;
                        if (acc_lock) begin
                            state    <= LOCKED;
                            lock_id  <= acc_id;
                            lock_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (owner_unlock || lock_expire) begin
                        state    <= UNLOCKED;
                        ptr      <= lock_next;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end

    // Stage p0 -> memory: register the accepted beat onto the DMEM port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            mem_byteena <= '0;
        end else begin
            mem_rden <= accept & ~acc_we;
            mem_wren <= accept & acc_we;
            if (accept) begin
                mem_address <= acc_addr;
                mem_data    <= acc_wdata;
                mem_byteena <= acc_be;
            end
        end
    end

    // Response pipe: tracks each issued beat until its data returns from memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_p[k] <= '0;
            end
        end else begin
            pipe_p[0] <= '{vld: accept, id: ID_W'(acc_id), we: acc_we};
            for (int k = 1; k < DEPTH; k++) begin
                pipe_p[k] <= pipe_p[k-1];
            end
        end
    end

    assign tail = pipe_p[DEPTH-1];

    // Route the retiring beat back to its requester; write acks carry zero data.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tail.vld && (tail.id == ID_W'(i));
        end
        rsp_we    = tail.vld & tail.we;
        rsp_rdata = (tail.vld && !tail.we) ? mem_q : '0;
    end

endmodule
